// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: sequences one decoded instruction over 3-5
// cycles and drives the datapath enables/muxes; parks in ERROR on unsupported ops.
// Decoded op encoding:    LW=0 SW=1 RTYPE=2 BEQ=3 ADDI=4 J=5 INVALID_OP=7 (6 also invalid)
// Decoded funct encoding: ADD=0 SUB=1 AND=2 OR=3 SLT=4 INVALID_FU=7 (5,6 also invalid)
module main_control_fsm #(
  parameter bit STRICT_FUNCT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [2:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       err,
  output logic [3:0] state_dbg
);

  localparam logic [2:0] OP_LW    = 3'd0;
  localparam logic [2:0] OP_SW    = 3'd1;
  localparam logic [2:0] OP_RTYPE = 3'd2;
  localparam logic [2:0] OP_BEQ   = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_J     = 3'd5;

  localparam logic [2:0] FU_ADD = 3'd0;
  localparam logic [2:0] FU_SUB = 3'd1;
  localparam logic [2:0] FU_AND = 3'd2;
  localparam logic [2:0] FU_OR  = 3'd3;
  localparam logic [2:0] FU_SLT = 3'd4;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ERROR    = 4'd12
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       err;
  } ctrl_t;

  // Control word seen in FETCH; also the reset value of the output registers.
  localparam ctrl_t FETCH_CTRL = '{
    default:     '0,
    ir_write:    1'b1,
    pc_write:    1'b1,
    alu_src_b:   2'b01,
    alu_control: ALU_ADD
  };

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;

  // Supported R-type function codes.
  function automatic logic funct_valid(input logic [2:0] f);
    return (f == FU_ADD) || (f == FU_SUB) || (f == FU_AND) ||
           (f == FU_OR)  || (f == FU_SLT);
  endfunction

  // R-type ALU operation; anything unsupported falls back to ADD.
  function automatic logic [2:0] alu_for_funct(input logic [2:0] f);
    logic [2:0] a;
    a = ALU_ADD;
    case (f)
      FU_SUB:  a = ALU_SUB;
      FU_AND:  a = ALU_AND;
      FU_OR:   a = ALU_OR;
      FU_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Moore control word for a state (funct matters only in EXECUTE).
  function automatic ctrl_t ctrl_for(input state_e s, input logic [2:0] f);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (s)
      S_FETCH:    c = FETCH_CTRL;
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_control = alu_for_funct(f); end
      S_ALUWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
        c.branch      = 1'b1;
      end
      S_ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_ERROR:    c.err = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic and control word for the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (STRICT_FUNCT && !funct_valid(funct)) ? S_ERROR : S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, funct);
  end

  // Output register, loaded alongside the state so it always matches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl_q <= FETCH_CTRL;
    else       ctrl_q <= ctrl_d;
  end

  assign iord        = ctrl_q.iord;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = ctrl_q.alu_control;
  assign pc_src      = ctrl_q.pc_src;
  assign err         = ctrl_q.err;
  assign state_dbg   = state_q;
  // Branch taken follows the live zero flag while in BRANCH.
  assign pc_en       = ctrl_q.pc_write | (ctrl_q.branch & zero);

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle MIPS main controller.
- Sits directly downstream of the opcode/funct decoder. It consumes the decoded `op` (OPECODE) and `funct` (FUNCT) from `lib_cpu` and sequences one instruction over 3–5 cycles.
- Drives all datapath enables and muxes: memory, instruction register, register file, ALU, PC.
- Latches into a terminal ERROR state on an unsupported instruction.

Parameters:
- STRICT_FUNCT, 1, 1: an R-type with `funct==INVALID_FU` goes to ERROR. 0: it executes as ADD.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  OPECODE  decoded opcode; stable from DECODE onward
- funct  in  FUNCT  decoded function field; stable from DECODE onward
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register select: 0=rt, 1=rd
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=Data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2
- alu_control  out  3  AND=000, OR=001, ADD=010, SUB=110, SLT=111
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  out  1  PC load = pc_write | (branch & zero)
- err  out  1  high while in ERROR
- state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM with a 4-bit state register. `reset` asynchronously forces FETCH.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, ERROR=12. Codes 13–15 go to FETCH.
- Outputs depend on state only, except:
  - `alu_control` in EXECUTE (decoded from `funct`);
  - `pc_en` (uses `zero`).
- Default for every output is 0; default `alu_control` is 010.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - LW, SW -> MEMADR
    - RTYPE -> EXECUTE, or ERROR if STRICT_FUNCT and funct==INVALID_FU
    - BEQ -> BRANCH
    - ADDI -> ADDIEXEC
    - J -> JUMP
    - INVALID_OP -> ERROR
  - MEMADR -> MEMRD if LW, MEMWR if SW.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - ERROR -> ERROR; leaves only via reset.
- Per-state outputs (unlisted outputs are at default):
  - FETCH: ir_write=1, pc_write=1, alu_src_b=01, add, pc_src=00, iord=0.
  - DECODE: alu_src_b=11, add (branch target precompute).
  - MEMADR: alu_src_a=1, alu_src_b=10, add.
  - MEMRD: iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
    - ADD -> 010, SUB -> 110, AND -> 000, OR -> 001, SLT -> 111
    - INVALID_FU -> 010 (reachable only when STRICT_FUNCT=0)
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, branch=1.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10, add.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - JUMP: pc_src=10, pc_write=1.
  - ERROR: err=1, all enables 0.
- Latency in cycles, FETCH to return to FETCH exclusive:
  - LW 5
  - SW, RTYPE, ADDI 4
  - BEQ, J 3
- Reset value of outputs = FETCH outputs:
  - ir_write=1, pc_en=1, alu_src_b=01, alu_control=010, state_dbg=0, err=0
  - all others 0
- Reset mid-instruction: the state returns to FETCH immediately and asynchronously, and no write strobe remains asserted after reset.
- In BRANCH, `pc_en` follows `zero` combinationally. Outside BRANCH, `zero` is ignored.
- `op`/`funct` are sampled only in DECODE and MEMADR. Changes in other states have no effect.

Test Plan:
- Reset, then `op=LW` -> state_dbg sequence 0,1,2,3,4,0.
  - iord=1 in state 3.
  - In state 4: reg_write=1, mem_to_reg=1.
  - pc_en=1 only in state 0.
- `op=RTYPE`, funct=SUB -> sequence 0,1,6,7,0.
  - alu_control=110 in state 6.
  - In state 7: reg_write=1, reg_dst=1.
  - Repeat for AND/OR/SLT/ADD, expecting 000/001/111/010.
- `op=BEQ` with zero=1 -> in state 8: pc_en=1, pc_src=01, alu_control=110.
  - Repeat with zero=0 -> pc_en=0.
  - Both cases return to 0 next cycle.
- `op=SW` -> sequence 0,1,2,5,0 with mem_write=1 only in state 5.
- `op=J` -> in state 11: pc_src=10, pc_en=1.
- `op=ADDI` -> sequence 0,1,9,10,0.
- Error and reset cases:
  - `op=INVALID_OP` -> state 12, err=1 held for ≥10 cycles, all enables 0.
  - Assert reset mid-MEMRD -> state_dbg=0 and ir_write=1 before the next clk edge.
  - With STRICT_FUNCT=0, RTYPE+INVALID_FU -> reaches ALUWB with alu_control=010.
